// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with mask, edge/level pending and EOI handshake
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   irq_src[N_SRC]   raw interrupt source requests
//   Addr[2]          register select (MASK, MODE, PEND, STAT)
//   we, data_in[32]  register write strobe and data
//   data_out[32]     combinational read data for Addr
//   int_ack          CP0 has taken the interrupt
//   int_req, int_id  registered request and index of requesting/in-service source
module irq_ctrl #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [1:0]       Addr,
  input  logic             we,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  input  logic             int_ack,
  output logic             int_req,
  output logic [2:0]       int_id
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t r_state, w_next;
  logic [N_SRC-1:0] r_mask, r_mode, r_pend, r_irq_q;
  logic [N_SRC-1:0] w_active, w_ack_clr, w_wr_clr, w_new_edge, w_edge_next, w_pend_next;
  logic [2:0] r_id, w_sel;
  logic r_req, w_any, w_ack, w_eoi, w_in_service, w_unused;
  assign w_unused = ^data_in[31:N_SRC];
  assign w_active = r_pend & r_mask;
  assign w_any = |w_active;
  assign w_ack = int_ack && r_state == REQ;
  assign w_eoi = we && Addr == 2'd3;
  always_comb begin
    w_sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (w_active[i]) w_sel = 3'(i);
  end
  // Edge bits: a new rising edge wins over a write-1 or ack clear in the same cycle.
  assign w_ack_clr = w_ack ? N_SRC'(1) << r_id : '0;
  assign w_wr_clr = (we && Addr == 2'd2) ? data_in[N_SRC-1:0] : '0;
  assign w_edge_next = (irq_src & ~r_irq_q) | (r_pend & ~w_wr_clr & ~w_ack_clr);
  assign w_pend_next = (r_mode & w_edge_next) | (~r_mode & irq_src);
  // Bits being switched from level to edge start cleared.
  assign w_new_edge = (we && Addr == 2'd1) ? data_in[N_SRC-1:0] & ~r_mode : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_pend  <= '0;
      r_irq_q <= '0;
    end else begin
      r_irq_q <= irq_src;
      r_pend  <= w_pend_next & ~w_new_edge;
      if (we && Addr == 2'd0) r_mask <= data_in[N_SRC-1:0];
      if (we && Addr == 2'd1) r_mode <= data_in[N_SRC-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
    end else begin
      r_state <= w_next;
      r_req   <= w_next == REQ;
      r_id    <= w_next == REQ ? w_sel : r_id;
    end
  end
  always_comb begin
    w_next = r_state == IDLE    ? (w_any ? REQ : IDLE) :
             r_state == REQ     ? (!w_any ? IDLE : int_ack ? SERVICE : REQ) :
             r_state == SERVICE ? (w_eoi ? IDLE : SERVICE) : IDLE;
  end
  always_comb begin
    w_in_service = r_state == SERVICE;
  end
  assign int_req = r_req;
  assign int_id = r_id;
  assign data_out = Addr == 2'd0 ? 32'(r_mask) :
                    Addr == 2'd1 ? 32'(r_mode) :
                    Addr == 2'd2 ? 32'(r_pend) : {28'b0, w_in_service, r_id};
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and randomized check of irq_ctrl against a behavioural model
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] irq_src = '0;
  logic [1:0] Addr = '0;
  logic we = 1'b0;
  logic [31:0] data_in = '0;
  logic int_ack = 1'b0;
  logic [31:0] data_out;
  logic int_req;
  logic [2:0] int_id;
  int checks = 0;
  int errors = 0;
  irq_ctrl #(.N_SRC(6)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .Addr(Addr), .we(we),
    .data_in(data_in), .data_out(data_out), .int_ack(int_ack),
    .int_req(int_req), .int_id(int_id)
  );
  always #5 clk = ~clk;
  bit [5:0] m_mask, m_mode, m_pend, m_q;
  bit [2:0] m_id;
  int m_st;
  bit m_valid = 1'b0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  always @(posedge clk) begin
    int sel;
    bit [5:0] np;
    if (reset) begin
      m_mask = '0; m_mode = '0; m_pend = '0; m_q = '0; m_id = '0; m_st = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      sel = -1;
      for (int i = 5; i >= 0; i--) if (m_pend[i] && m_mask[i]) sel = i;
      for (int i = 0; i < 6; i++) begin
        if (m_mode[i]) begin
          if (irq_src[i] && !m_q[i]) np[i] = 1'b1;
          else if ((we && Addr == 2 && data_in[i]) || (int_ack && m_st == 1 && m_id == i)) np[i] = 1'b0;
          else np[i] = m_pend[i];
        end else np[i] = irq_src[i];
        if (we && Addr == 1 && data_in[i] && !m_mode[i]) np[i] = 1'b0;
      end
      if (m_st == 0) begin
        if (sel >= 0) begin m_id = 3'(sel); m_st = 1; end
      end else if (m_st == 1) begin
        if (sel < 0) m_st = 0;
        else if (int_ack) m_st = 2;
        else m_id = 3'(sel);
      end else if (we && Addr == 3) m_st = 0;
      if (we && Addr == 0) m_mask = data_in[5:0];
      if (we && Addr == 1) m_mode = data_in[5:0];
      m_pend = np;
      m_q = irq_src;
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("int_req", 32'(int_req), 32'(m_st == 1));
      chk("int_id", 32'(int_id), 32'(m_id));
      chk("data_out", data_out,
          Addr == 0 ? 32'(m_mask) : Addr == 1 ? 32'(m_mode) :
          Addr == 2 ? 32'(m_pend) : {28'b0, m_st == 2, m_id});
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; data_in = d; we = 1'b1;
    tick;
    we = 1'b0;
  endtask
  task automatic lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = a;
    @(negedge clk);
    chk(name, data_out, exp);
  endtask
  task automatic rq(input string name, input logic [3:0] exp);
    @(negedge clk);
    chk(name, {28'b0, int_req, int_id}, {28'b0, exp});
  endtask
  task automatic ack;
    int_ack = 1'b1;
    tick;
    int_ack = 1'b0;
  endtask
  initial begin
    tick; tick;
    reset = 1'b0;
    rq("reset_req", 4'h0);
    lit("reset_mask", 2'd0, 32'h0);
    // 1: level source 2
    wr(0, 32'h3F);
    irq_src = 6'h04; tick; tick;
    rq("t1_req", 4'hA);
    ack;
    lit("t1_stat", 2'd3, 32'hA);
    rq("t1_svc_noreq", 4'h2);
    wr(3, 0); tick;
    rq("t1_rereq", 4'hA);
    irq_src = 6'h00; ack; wr(3, 0);
    // 2: edge pulse on source 4
    wr(1, 32'h3F);
    irq_src = 6'h10; tick; irq_src = 6'h00;
    lit("t2_pend", 2'd2, 32'h10);
    tick;
    rq("t2_req", 4'hC);
    ack;
    lit("t2_pend_clr", 2'd2, 32'h0);
    irq_src = 6'h10; tick; irq_src = 6'h00;
    lit("t2_pend_svc", 2'd2, 32'h10);
    rq("t2_svc", 4'h4);
    wr(3, 0); tick;
    rq("t2_after_eoi", 4'hC);
    ack; wr(3, 0);
    // 3: priority and preemption
    wr(1, 0);
    irq_src = 6'b001010; tick; tick;
    rq("t3_prio", 4'h9);
    irq_src = 6'h00; ack; wr(3, 0);
    irq_src = 6'b001000; tick; tick;
    rq("t3_src3", 4'hB);
    irq_src = 6'b001001; tick;
    rq("t3_pre_hold", 4'hB);
    tick;
    rq("t3_preempt", 4'h8);
    irq_src = 6'h00; ack; wr(3, 0);
    // 4: mask drop in REQ
    irq_src = 6'b100000; tick; tick;
    rq("t4_req", 4'hD);
    wr(0, 32'h1F);
    rq("t4_old_mask", 4'hD);
    tick;
    rq("t4_drop", 4'h5);
    lit("t4_stat", 2'd3, 32'h5);
    irq_src = 6'h00; wr(0, 32'h3F);
    // 5: edge vs clear collision, ignored ack/EOI
    wr(0, 0); wr(1, 1);
    irq_src = 6'h01; Addr = 2'd2; data_in = 32'h1; we = 1'b1; tick; we = 1'b0; data_in = 0;
    lit("t5_set_wins", 2'd2, 32'h1);
    ack;
    rq("t5_ack_idle", 4'h5);
    lit("t5_stat_ack", 2'd3, 32'h5);
    wr(3, 0);
    lit("t5_stat_eoi", 2'd3, 32'h5);
    lit("t5_pend_kept", 2'd2, 32'h1);
    irq_src = 6'h00; wr(2, 1); wr(0, 32'h3F); wr(1, 0);
    // 6: reset during service
    irq_src = 6'h04; tick; tick;
    rq("t6_req", 4'hA);
    ack;
    lit("t6_svc", 2'd3, 32'hA);
    wr(1, 32'h0C);
    irq_src = 6'h00; reset = 1'b1; tick; reset = 1'b0;
    rq("t6_req_rst", 4'h0);
    lit("t6_mask", 2'd0, 32'h0);
    lit("t6_mode", 2'd1, 32'h0);
    lit("t6_pend", 2'd2, 32'h0);
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ 6'($urandom);
      Addr = 2'($urandom);
      we = ($urandom_range(0, 4) == 0);
      data_in = $urandom;
      int_ack = ($urandom_range(0, 2) == 0);
      tick;
    end
    reset = 1'b0; we = 1'b0; int_ack = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
